// File: rtl/write_burst_feeder.sv
// write_burst_feeder: takes one burst command plus a stream of data beats and
// replays them to the write master as memoryWrite pulses, one beat per pulse
// with a low gap between pulses. Tracks master buffer credit and outstanding
// bursts, and retires a burst when the master's response strobe arrives.
module write_burst_feeder #(
  parameter int buswidth    = 32,
  parameter int DFIFO_DEPTH = 16,
  parameter int WM_DEPTH    = 64,
  parameter int MAX_BURSTS  = 4
) (
  input  logic                devclock,
  input  logic                ARESETn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd_id,
  input  logic [31:0]         cmd_addr,
  input  logic [3:0]          cmd_len,
  input  logic [2:0]          cmd_size,
  input  logic [1:0]          cmd_burst,
  input  logic [buswidth-1:0] wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic                resp_strobe,
  input  logic [1:0]          resp_code,
  output logic                memoryWrite,
  output logic [buswidth-1:0] Datain,
  output logic [3:0]          ID,
  output logic [3:0]          WWID,
  output logic [31:0]         WADDR,
  output logic [3:0]          WLEN,
  output logic [2:0]          WSIZE,
  output logic [1:0]          WBURST,
  output logic                busy,
  output logic [7:0]          err_count,
  output logic [1:0]          last_resp
);
  localparam int DAW = $clog2(DFIFO_DEPTH);
  localparam int LAW = $clog2(MAX_BURSTS);
  localparam int CW  = $clog2(WM_DEPTH) + 1;
  localparam int OW  = $clog2(MAX_BURSTS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PULSE, S_GAP} state_t;
  state_t state;

  // data FIFO: extra pointer bit distinguishes full from empty
  logic [buswidth-1:0] dmem [DFIFO_DEPTH];
  logic [DAW:0]        dwptr, drptr;
  logic                dempty, dfull, dpush, dpop;

  // length FIFO: one entry per outstanding burst, returns its credit on response
  logic [3:0]     lmem [MAX_BURSTS];
  logic [LAW-1:0] lwptr, lrptr;

  logic [OW-1:0] outstanding, outstanding_n;
  logic [CW-1:0] credit, credit_n, cmd_beats, resp_beats;
  logic [3:0]    beat_cnt;
  logic          cmd_fire, resp_pop, fsm_active_n;

  assign dempty   = (dwptr == drptr);
  assign dfull    = (dwptr[DAW] != drptr[DAW]) && (dwptr[DAW-1:0] == drptr[DAW-1:0]);
  assign wr_ready = !dfull;
  assign dpush    = wr_valid && !dfull;
  assign dpop     = (state == S_WAIT) && !dempty;

  assign cmd_beats  = CW'(cmd_len) + CW'(1);
  assign resp_beats = CW'(lmem[lrptr]) + CW'(1);
  assign cmd_ready  = (state == S_IDLE) && (credit >= cmd_beats) &&
                      (outstanding < OW'(MAX_BURSTS));
  assign cmd_fire   = cmd_valid && cmd_ready;
  // a strobe with nothing outstanding is spurious and has no effect at all
  assign resp_pop   = resp_strobe && (outstanding != '0);

  // FSM still busy after this edge: new accept, or mid-burst and not on the final pulse
  assign fsm_active_n = cmd_fire ||
                        ((state != S_IDLE) && !((state == S_PULSE) && (beat_cnt == WLEN)));

  // next credit/outstanding; accept and response in one cycle apply both deltas
  always_comb begin
    credit_n      = credit;
    outstanding_n = outstanding;
    if (cmd_fire) begin
      credit_n      = credit_n - cmd_beats;
      outstanding_n = outstanding_n + OW'(1);
    end
    if (resp_pop) begin
      credit_n      = credit_n + resp_beats;
      outstanding_n = outstanding_n - OW'(1);
    end
  end

  // FIFO storage arrays (no reset needed; pointers define validity)
  always_ff @(posedge devclock) begin
    if (ARESETn && dpush)    dmem[dwptr[DAW-1:0]] <= wr_data;
    if (ARESETn && cmd_fire) lmem[lwptr]          <= cmd_len;
  end

  // data FIFO pointers
  always_ff @(posedge devclock) begin
    if (!ARESETn) begin
      dwptr <= '0;
      drptr <= '0;
    end else begin
      if (dpush) dwptr <= dwptr + (DAW+1)'(1);
      if (dpop)  drptr <= drptr + (DAW+1)'(1);
    end
  end

  // credit, outstanding bursts, response bookkeeping and busy
  always_ff @(posedge devclock) begin
    if (!ARESETn) begin
      credit      <= CW'(WM_DEPTH);
      outstanding <= '0;
      lwptr       <= '0;
      lrptr       <= '0;
      busy        <= 1'b0;
      err_count   <= '0;
      last_resp   <= '0;
    end else begin
      credit      <= credit_n;
      outstanding <= outstanding_n;
      if (cmd_fire) lwptr <= lwptr + LAW'(1);
      if (resp_pop) begin
        lrptr     <= lrptr + LAW'(1);
        last_resp <= resp_code;
        if ((resp_code != 2'b00) && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      end
      busy <= fsm_active_n || (outstanding_n != '0);
    end
  end

  // burst sequencer: latch command, then WAIT -> PULSE -> GAP per beat
  always_ff @(posedge devclock) begin
    if (!ARESETn) begin
      state       <= S_IDLE;
      memoryWrite <= 1'b0;
      Datain      <= '0;
      ID          <= '0;
      WWID        <= '0;
      WADDR       <= '0;
      WLEN        <= '0;
      WSIZE       <= '0;
      WBURST      <= '0;
      beat_cnt    <= '0;
    end else begin
      memoryWrite <= 1'b0;
      case (state)
        S_IDLE: if (cmd_fire) begin
          ID       <= cmd_id;
          WWID     <= cmd_id;
          WADDR    <= cmd_addr;
          WLEN     <= cmd_len;
          WSIZE    <= cmd_size;
          WBURST   <= cmd_burst;
          beat_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: if (!dempty) begin
          Datain      <= dmem[drptr[DAW-1:0]];
          memoryWrite <= 1'b1;
          state       <= S_PULSE;
        end
        S_PULSE: begin
          if (beat_cnt == WLEN) state <= S_IDLE;
          else begin
            beat_cnt <= beat_cnt + 4'd1;
            state    <= S_GAP;
          end
        end
        S_GAP:   state <= S_WAIT;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_write_burst_feeder.sv
// Directed bench for write_burst_feeder: a table of complete bursts plus
// hand-written sequences for starvation, credit/outstanding limits,
// mid-burst reset and error response accounting.
module tb_write_burst_feeder;
  logic        devclock = 1'b0;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_id, cmd_len;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic        resp_strobe;
  logic [1:0]  resp_code;
  logic        memoryWrite;
  logic [31:0] Datain;
  logic [3:0]  ID, WWID, WLEN;
  logic [31:0] WADDR;
  logic [2:0]  WSIZE;
  logic [1:0]  WBURST;
  logic        busy;
  logic [7:0]  err_count;
  logic [1:0]  last_resp;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 devclock = ~devclock;

  write_burst_feeder dut (
    .devclock(devclock), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .resp_strobe(resp_strobe), .resp_code(resp_code),
    .memoryWrite(memoryWrite), .Datain(Datain), .ID(ID), .WWID(WWID), .WADDR(WADDR),
    .WLEN(WLEN), .WSIZE(WSIZE), .WBURST(WBURST), .busy(busy),
    .err_count(err_count), .last_resp(last_resp)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] dbase;
    logic [1:0]  rcode;
    logic [7:0]  exp_err;
    logic [1:0]  exp_last;
  } vec_t;
  vec_t tv[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge devclock);
    #1;
  endtask

  task automatic push_beat(input logic [31:0] d);
    chk("wr_ready", 32'(wr_ready), 32'd1);
    wr_data  = d;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
  endtask

  // returns just after the accepting edge
  task automatic send_cmd(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int c;
    cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
    cmd_valid = 1'b1;
    #1;
    c = 0;
    while (cmd_ready !== 1'b1 && c < 40) begin
      step();
      c++;
    end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_pulse(input string nm, output int c);
    c = 0;
    while (memoryWrite !== 1'b1 && c < 40) begin
      step();
      c++;
    end
    chk(nm, 32'(memoryWrite), 32'd1);
  endtask

  task automatic run_beats(input int n, input logic [31:0] base, input string nm);
    int c;
    for (int i = 0; i < n; i++) begin
      wait_pulse(nm, c);
      chk({nm, "_data"}, Datain, base + 32'(i));
      step();
    end
  endtask

  task automatic resp(input logic [1:0] code);
    resp_code   = code;
    resp_strobe = 1'b1;
    step();
    resp_strobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    tv[0] = '{4'h5, 32'h0000_0100, 4'd3,  3'd2, 2'd1, 32'hA000_0000, 2'b00, 8'd0, 2'b00};
    tv[1] = '{4'hA, 32'h0000_2000, 4'd0,  3'd2, 2'd0, 32'h0000_00B0, 2'b10, 8'd1, 2'b10};
    tv[2] = '{4'hF, 32'hFFFF_FFFC, 4'd15, 3'd2, 2'd1, 32'h0000_0C00, 2'b11, 8'd2, 2'b11};
    tv[3] = '{4'h0, 32'h0000_0040, 4'd7,  3'd1, 2'd2, 32'h0000_00D0, 2'b01, 8'd3, 2'b01};
    tv[4] = '{4'h3, 32'h0000_0080, 4'd1,  3'd0, 2'd1, 32'h1234_0000, 2'b00, 8'd3, 2'b00};

    // T1: reset held with everything active
    ARESETn = 1'b0; cmd_valid = 1'b1; cmd_id = 4'h7; cmd_addr = 32'hDEAD; cmd_len = 4'd2;
    cmd_size = 3'd2; cmd_burst = 2'd1; wr_valid = 1'b1; wr_data = 32'h55;
    resp_strobe = 1'b1; resp_code = 2'b10;
    repeat (3) step();
    chk("rst_mw",    32'(memoryWrite), 32'd0);
    chk("rst_data",  Datain,           32'd0);
    chk("rst_id",    32'(ID),          32'd0);
    chk("rst_wwid",  32'(WWID),        32'd0);
    chk("rst_waddr", WADDR,            32'd0);
    chk("rst_wlen",  32'(WLEN),        32'd0);
    chk("rst_wsize", 32'(WSIZE),       32'd0);
    chk("rst_wburst",32'(WBURST),      32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_err",   32'(err_count),   32'd0);
    chk("rst_last",  32'(last_resp),   32'd0);
    ARESETn = 1'b1; cmd_valid = 1'b0; wr_valid = 1'b0; resp_strobe = 1'b0; resp_code = 2'b00;
    cmd_len = 4'd0;
    #1;
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rel_wr_ready",  32'(wr_ready),  32'd1);
    step();

    // table of full bursts (T2 is entry 0)
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i <= int'(tv[v].len); i++) push_beat(tv[v].dbase + 32'(i));
      if (tv[v].len == 4'd15) chk("fifo_full_ready", 32'(wr_ready), 32'd0);
      send_cmd(tv[v].id, tv[v].addr, tv[v].len, tv[v].size, tv[v].burst);
      chk("lat_accept_low", 32'(memoryWrite), 32'd0);
      for (int i = 0; i <= int'(tv[v].len); i++) begin
        if (i == 0) step();
        else begin
          wait_pulse("pulse", c);
          chk("spacing", 32'(c), 32'd2);
        end
        chk("pulse_high", 32'(memoryWrite), 32'd1);
        chk("datain",     Datain,           tv[v].dbase + 32'(i));
        chk("id",         32'(ID),          32'(tv[v].id));
        chk("wwid",       32'(WWID),        32'(tv[v].id));
        chk("waddr",      WADDR,            tv[v].addr);
        chk("wlen",       32'(WLEN),        32'(tv[v].len));
        chk("wsize",      32'(WSIZE),       32'(tv[v].size));
        chk("wburst",     32'(WBURST),      32'(tv[v].burst));
        chk("busy_burst", 32'(busy),        32'd1);
        step();
        chk("gap_low", 32'(memoryWrite), 32'd0);
      end
      repeat (4) begin
        step();
        chk("no_extra_pulse", 32'(memoryWrite), 32'd0);
      end
      chk("busy_wait_resp", 32'(busy), 32'd1);
      resp(tv[v].rcode);
      chk("busy_retired", 32'(busy),      32'd0);
      chk("err_count",    32'(err_count), 32'(tv[v].exp_err));
      chk("last_resp",    32'(last_resp), 32'(tv[v].exp_last));
    end

    // T3: data starvation between beats
    push_beat(32'h300);
    send_cmd(4'h1, 32'h300, 4'd1, 3'd2, 2'd1);
    run_beats(1, 32'h300, "t3_b0");
    repeat (10) begin
      step();
      chk("t3_starve_low", 32'(memoryWrite), 32'd0);
    end
    chk("t3_busy", 32'(busy), 32'd1);
    push_beat(32'h301);
    wait_pulse("t3_b1", c);
    chk("t3_b1_data",  Datain, 32'h301);
    chk("t3_b1_waddr", WADDR,  32'h300);
    step();
    repeat (3) begin
      step();
      chk("t3_done_low", 32'(memoryWrite), 32'd0);
    end
    resp(2'b00);
    chk("t3_busy_done", 32'(busy), 32'd0);

    // T4: credit and outstanding limits
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) push_beat(32'h400 + 32'(k * 16 + i));
      send_cmd(4'(k), 32'h1000 * 32'(k + 1), 4'd15, 3'd2, 2'd1);
      run_beats(16, 32'h400 + 32'(k * 16), "t4_beat");
    end
    cmd_len = 4'd15;
    #1;
    chk("t4_credit_equal", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 16; i++) push_beat(32'h430 + 32'(i));
    send_cmd(4'h3, 32'h4000, 4'd15, 3'd2, 2'd1);
    run_beats(16, 32'h430, "t4_beat4");
    cmd_len = 4'd0; cmd_valid = 1'b1;
    #1;
    repeat (3) begin
      chk("t4_fifth_blocked", 32'(cmd_ready), 32'd0);
      step();
    end
    resp(2'b00);
    chk("t4_after_resp", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    push_beat(32'h4F0);
    run_beats(1, 32'h4F0, "t4_fifth");
    chk("t4_out_full", 32'(cmd_ready), 32'd0);
    resp(2'b00);
    // accept and response on the same edge: outstanding must stay at 3
    cmd_len = 4'd0; cmd_valid = 1'b1; resp_code = 2'b00; resp_strobe = 1'b1;
    #1;
    chk("t4_same_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0; resp_strobe = 1'b0;
    push_beat(32'h4F1);
    run_beats(1, 32'h4F1, "t4_same");
    chk("t4_same_out3", 32'(cmd_ready), 32'd1);
    push_beat(32'h4F2);
    send_cmd(4'h6, 32'h4F00, 4'd0, 3'd2, 2'd1);
    run_beats(1, 32'h4F2, "t4_last");
    chk("t4_same_out4", 32'(cmd_ready), 32'd0);
    repeat (3) resp(2'b00);
    chk("t4_busy_one_left", 32'(busy), 32'd1);
    resp(2'b00);
    chk("t4_busy_drained", 32'(busy), 32'd0);

    // T6: reset while pulsing beat 2 of a LEN=7 burst
    for (int i = 0; i < 8; i++) push_beat(32'h600 + 32'(i));
    send_cmd(4'h2, 32'h600, 4'd7, 3'd2, 2'd1);
    run_beats(2, 32'h600, "t6_pre");
    wait_pulse("t6_b2", c);
    chk("t6_b2_data", Datain, 32'h602);
    ARESETn = 1'b0;
    step();
    chk("t6_mw",    32'(memoryWrite), 32'd0);
    chk("t6_busy",  32'(busy),        32'd0);
    chk("t6_data",  Datain,           32'd0);
    chk("t6_waddr", WADDR,            32'd0);
    chk("t6_id",    32'(ID),          32'd0);
    chk("t6_err",   32'(err_count),   32'd0);
    chk("t6_last",  32'(last_resp),   32'd0);
    step();
    ARESETn = 1'b1;
    send_cmd(4'h9, 32'h700, 4'd0, 3'd2, 2'd1);
    repeat (5) begin
      step();
      chk("t6_fifo_empty", 32'(memoryWrite), 32'd0);
    end
    push_beat(32'h7E0);
    run_beats(1, 32'h7E0, "t6_fresh");
    resp(2'b00);
    chk("t6_busy_done", 32'(busy), 32'd0);

    // T5: SLVERR responses and a spurious strobe
    for (int k = 0; k < 3; k++) begin
      push_beat(32'h500 + 32'(k));
      send_cmd(4'(k), 32'h500, 4'd0, 3'd2, 2'd1);
      run_beats(1, 32'h500 + 32'(k), "t5_beat");
    end
    resp(2'b10);
    resp(2'b10);
    chk("t5_busy_mid", 32'(busy), 32'd1);
    resp(2'b10);
    chk("t5_err",  32'(err_count), 32'd3);
    chk("t5_last", 32'(last_resp), 32'd2);
    chk("t5_busy", 32'(busy),      32'd0);
    resp(2'b11);
    chk("t5_ignored_err",  32'(err_count), 32'd3);
    chk("t5_ignored_last", 32'(last_resp), 32'd2);
    chk("t5_no_underflow_busy",  32'(busy),      32'd0);
    chk("t5_no_underflow_ready", 32'(cmd_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
